// File: rtl/boss_sched_pkg.sv
// Shared encodings and helpers for the boss attack scheduler.
// Imported by boss_attack_sched and sched_tick_timer.
package boss_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WARMUP   = 3'd1,
    ST_SPREAD   = 3'd2,
    ST_BIG      = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_HOLD     = 3'd5
  } sched_state_e;

  typedef enum logic [1:0] {
    PHASE_0 = 2'd0,
    PHASE_1 = 2'd1,
    PHASE_2 = 2'd2
  } phase_e;

  localparam logic [5:0] SLOT_SPREAD_MASK = 6'h1F;
  localparam int         SLOT_BIG         = 5;

  // Timer loads never exceed the 8-bit range and never request zero ticks.
  function automatic logic [7:0] sat_load(input int unsigned n);
    logic [7:0] r;
    if (n > 32'd255) begin
      r = 8'd255;
    end else if (n == 32'd0) begin
      r = 8'd1;
    end else begin
      r = n[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/boss_attack_sched_timer.sv
// Module sched_tick_timer: 8-bit load/decrement tick timer for the scheduler's timed states.
// A load of 0 is stretched to 1; the count parks at 0 instead of wrapping.
module sched_tick_timer
  import boss_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expire
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (load) begin
      count_d = (load_val == 8'd0) ? 8'd1 : load_val;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // A state loaded with N sees N..1; zero also expires so a timed state cannot stall.
  assign expire = (count_q <= 8'd1);

endmodule

// File: rtl/boss_attack_sched.sv
// Boss attack-pattern scheduler: paces spread volleys and big-bullet launches by HP phase.
// Optional BOSS_RAGE_EN: faster phase-2 cooldown, and hits in phase 2 go to COOLDOWN instead of HOLD.
module boss_attack_sched
  import boss_sched_pkg::*;
#(
  parameter int         WARMUP_TICKS    = 30,
  parameter int         COOLDOWN_TICKS  = 24,
  parameter int         VOLLEYS_PER_BIG = 3,
  parameter int         HIT_HOLD_TICKS  = 40,
  parameter logic [7:0] PHASE2_HP       = 8'd160,
  parameter logic [7:0] PHASE3_HP       = 8'd64
) (
  input  logic       clk22,
  input  logic       rst_n,
  input  logic       boss,
  input  logic       gamestart,
  input  logic [7:0] boss_hp,
  input  logic [5:0] slot_busy,
  input  logic       player_hit,
  output logic [5:0] fire,
  output logic [1:0] phase,
  output logic [2:0] sched_state,
  output logic [1:0] volley_cnt
);

  sched_state_e state_q, state_d;
  logic [5:0]   fire_q, fire_d;
  phase_e       phase_q, phase_d;
  logic [1:0]   volley_q, volley_d;

  logic         tmr_clr;
  logic         tmr_load;
  logic [7:0]   tmr_val;
  logic         tmr_expire;

  logic [7:0]   warmup_load;
  logic [7:0]   hold_load;
  logic [7:0]   cd_load;
  logic [2:0]   volley_inc;

  sched_tick_timer u_timer (
    .clk      (clk22),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign warmup_load = sat_load(WARMUP_TICKS);
  assign hold_load   = sat_load(HIT_HOLD_TICKS);
  assign volley_inc  = {1'b0, volley_q} + 3'd1;

  // Cooldown length follows the registered phase at the moment COOLDOWN is entered.
  always_comb begin
    cd_load = sat_load(COOLDOWN_TICKS);
    case (phase_q)
      PHASE_1: cd_load = sat_load(COOLDOWN_TICKS >> 1);
`ifdef BOSS_RAGE_EN
      PHASE_2: cd_load = sat_load(COOLDOWN_TICKS >> 3);
`else
      PHASE_2: cd_load = sat_load(COOLDOWN_TICKS >> 2);
`endif
      default: cd_load = sat_load(COOLDOWN_TICKS);
    endcase
  end

  always_comb begin
    phase_d = PHASE_2;
    if (boss_hp >= PHASE2_HP) begin
      phase_d = PHASE_0;
    end else if (boss_hp >= PHASE3_HP) begin
      phase_d = PHASE_1;
    end
  end

  always_comb begin
    state_d  = state_q;
    fire_d   = 6'h00;
    volley_d = volley_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = 8'd0;

    if (!boss || gamestart) begin
      state_d  = ST_IDLE;
      volley_d = 2'd0;
      tmr_clr  = 1'b1;
    end else if (player_hit && (state_q != ST_IDLE)) begin
`ifdef BOSS_RAGE_EN
      if (phase_q == PHASE_2) begin
        state_d  = ST_COOLDOWN;
        tmr_load = 1'b1;
        tmr_val  = cd_load;
      end else begin
        state_d  = ST_HOLD;
        tmr_load = 1'b1;
        tmr_val  = hold_load;
      end
`else
      state_d  = ST_HOLD;
      tmr_load = 1'b1;
      tmr_val  = hold_load;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_WARMUP;
          tmr_load = 1'b1;
          tmr_val  = warmup_load;
        end
        ST_WARMUP, ST_COOLDOWN, ST_HOLD: begin
          if (tmr_expire) begin
            state_d = ST_SPREAD;
          end
        end
        ST_SPREAD: begin
          if ((slot_busy & SLOT_SPREAD_MASK) == 6'h00) begin
            fire_d   = SLOT_SPREAD_MASK;
            volley_d = volley_inc[1:0];
            if (int'(volley_inc) >= VOLLEYS_PER_BIG) begin
              state_d = ST_BIG;
            end else begin
              state_d  = ST_COOLDOWN;
              tmr_load = 1'b1;
              tmr_val  = cd_load;
            end
          end
        end
        ST_BIG: begin
          if (!slot_busy[SLOT_BIG]) begin
            fire_d[SLOT_BIG] = 1'b1;
            volley_d         = 2'd0;
            state_d          = ST_COOLDOWN;
            tmr_load         = 1'b1;
            tmr_val          = cd_load;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk22 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      fire_q   <= 6'h00;
      phase_q  <= PHASE_0;
      volley_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      fire_q   <= fire_d;
      phase_q  <= phase_d;
      volley_q <= volley_d;
    end
  end

  assign fire        = fire_q;
  assign phase       = phase_q;
  assign sched_state = state_q;
  assign volley_cnt  = volley_q;

endmodule

// File: tb/tb_boss_attack_sched.sv
// Directed bench for boss_attack_sched: volley pacing, big launch, phases, hit hold, gamestart, async reset.
// Expected values follow BOSS_RAGE_EN the same way the design does.
module tb_boss_attack_sched;

  logic       clk22 = 1'b0;
  logic       rst_n;
  logic       boss;
  logic       gamestart;
  logic [7:0] boss_hp;
  logic [5:0] slot_busy;
  logic       player_hit;
  logic [5:0] fire;
  logic [1:0] phase;
  logic [2:0] sched_state;
  logic [1:0] volley_cnt;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [5:0] exp_q[$];

`ifdef BOSS_RAGE_EN
  localparam int P2_GAP = 4;
`else
  localparam int P2_GAP = 7;
`endif

  boss_attack_sched dut (
    .clk22       (clk22),
    .rst_n       (rst_n),
    .boss        (boss),
    .gamestart   (gamestart),
    .boss_hp     (boss_hp),
    .slot_busy   (slot_busy),
    .player_hit  (player_hit),
    .fire        (fire),
    .phase       (phase),
    .sched_state (sched_state),
    .volley_cnt  (volley_cnt)
  );

  // clock / reset
  always #5 clk22 = ~clk22;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk22);
  endtask

  task automatic wait_fire(input int max, output int n);
    n = 0;
    while (fire == 6'h00 && n < max) begin
      @(negedge clk22);
      n++;
    end
  endtask

  // Step off the current launch cycle, then count cycles to the next launch.
  task automatic next_fire(input int max, output int gap);
    logic [5:0] prev;
    int n;
    prev = fire;
    @(negedge clk22);
    check("fire_no_repeat", {26'd0, fire & prev}, 32'd0);
    wait_fire(max, n);
    gap = n + 1;
  endtask

  // scoreboard: every launch pulse must match the next expected pattern
  always @(negedge clk22) begin
    if (rst_n && fire != 6'h00) begin
      if (exp_q.size() == 0) begin
        check("fire_extra", {26'd0, fire}, 32'd0);
      end else begin
        check("fire_seq", {26'd0, fire}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int n;
    int gap;
    logic saw;

    rst_n      = 1'b0;
    boss       = 1'b0;
    gamestart  = 1'b0;
    boss_hp    = 8'd200;
    slot_busy  = 6'h00;
    player_hit = 1'b0;
    exp_q = '{6'h1F, 6'h1F, 6'h1F, 6'h20, 6'h1F, 6'h1F, 6'h1F, 6'h20, 6'h1F, 6'h1F, 6'h1F, 6'h1F};

    tick(2);
    check("rst_state", {29'd0, sched_state}, 32'd0);
    check("rst_fire", {26'd0, fire}, 32'd0);
    check("rst_phase", {30'd0, phase}, 32'd0);
    check("rst_volley", {30'd0, volley_cnt}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("idle_no_boss", {29'd0, sched_state}, 32'd0);

    // phase thresholds, 1-cycle latency
    boss_hp = 8'd160; tick(1); check("phase_hp160", {30'd0, phase}, 32'd0);
    boss_hp = 8'd159; tick(1); check("phase_hp159", {30'd0, phase}, 32'd1);
    boss_hp = 8'd64;  tick(1); check("phase_hp64", {30'd0, phase}, 32'd1);
    boss_hp = 8'd63;  tick(1); check("phase_hp63", {30'd0, phase}, 32'd2);
    boss_hp = 8'd200; tick(1); check("phase_hp200", {30'd0, phase}, 32'd0);

    // warmup: 30 WARMUP cycles, 1 SPREAD decision cycle, launch visible on the next
    boss = 1'b1;
    tick(1);
    check("warmup_entry", {29'd0, sched_state}, 32'd1);
    wait_fire(100, n);
    check("warmup_to_fire", n, 31);
    check("v1_cnt", {30'd0, volley_cnt}, 32'd1);
    check("v1_state", {29'd0, sched_state}, 32'd4);

    // 24 COOLDOWN cycles + decision cycle between launches
    next_fire(100, gap);
    check("cooldown_gap_p0", gap, 25);
    check("v2_cnt", {30'd0, volley_cnt}, 32'd2);

    // third volley leads to BIG; big slot busy for 10 cycles
    next_fire(100, gap);
    check("v3_gap", gap, 25);
    check("v3_state_big", {29'd0, sched_state}, 32'd3);
    check("v3_cnt", {30'd0, volley_cnt}, 32'd3);
    slot_busy = 6'h20;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (fire != 6'h00) saw = 1'b1;
    end
    check("big_wait_quiet", {31'd0, saw}, 32'd0);
    check("big_wait_state", {29'd0, sched_state}, 32'd3);
    slot_busy = 6'h00;
    tick(1);
    check("big_fire", {26'd0, fire}, 32'h20);
    check("big_volley_clr", {30'd0, volley_cnt}, 32'd0);
    check("big_to_cooldown", {29'd0, sched_state}, 32'd4);

    // a busy spread slot parks the scheduler in SPREAD
    slot_busy = 6'h04;
    tick(30);
    check("spread_parked", {29'd0, sched_state}, 32'd2);
    slot_busy = 6'h00;
    tick(1);
    check("spread_release", {26'd0, fire}, 32'h1F);
    check("spread_release_cnt", {30'd0, volley_cnt}, 32'd1);

    // phase 2: current cooldown was loaded in phase 0, later ones are short
    boss_hp = 8'd50;
    tick(1);
    check("phase2", {30'd0, phase}, 32'd2);
    wait_fire(100, n);
    check("cooldown_sampled_on_entry", n, 24);
    next_fire(100, gap);
    check("cooldown_gap_p2", gap, P2_GAP);
    check("p2_big_state", {29'd0, sched_state}, 32'd3);
    next_fire(100, gap);
    check("p2_big_gap", gap, 1);
    check("p2_big_fire", {26'd0, fire}, 32'h20);
    next_fire(100, gap);
    check("cooldown_gap_after_big", gap, P2_GAP);
    check("p2_v1_cnt", {30'd0, volley_cnt}, 32'd1);

    // hit on the same cycle the spread slots free up
    boss_hp   = 8'd200;
    slot_busy = 6'h01;
    tick(12);
    check("hit_pre_spread", {29'd0, sched_state}, 32'd2);
    check("hit_pre_phase", {30'd0, phase}, 32'd0);
    slot_busy  = 6'h00;
    player_hit = 1'b1;
    tick(1);
    player_hit = 1'b0;
    check("hit_no_fire", {26'd0, fire}, 32'd0);
    check("hit_state_hold", {29'd0, sched_state}, 32'd5);
    check("hit_volley_kept", {30'd0, volley_cnt}, 32'd1);
    wait_fire(100, n);
    check("hold_to_fire", n, 41);
    check("hold_fire_cnt", {30'd0, volley_cnt}, 32'd2);

    // gamestart while BIG is ready to launch
    slot_busy = 6'h20;
    next_fire(100, gap);
    check("gs_pre_gap", gap, 25);
    check("gs_pre_big", {29'd0, sched_state}, 32'd3);
    tick(3);
    slot_busy = 6'h00;
    gamestart = 1'b1;
    tick(1);
    gamestart = 1'b0;
    check("gs_no_fire", {26'd0, fire}, 32'd0);
    check("gs_state_idle", {29'd0, sched_state}, 32'd0);
    check("gs_volley_clr", {30'd0, volley_cnt}, 32'd0);
    tick(1);
    check("gs_rewarm", {29'd0, sched_state}, 32'd1);

    // async reset in the middle of COOLDOWN
    wait_fire(100, n);
    check("rewarm_to_fire", n, 31);
    boss_hp = 8'd50;
    tick(5);
    check("pre_rst_cooldown", {29'd0, sched_state}, 32'd4);
    check("pre_rst_phase", {30'd0, phase}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", {29'd0, sched_state}, 32'd0);
    check("async_rst_phase", {30'd0, phase}, 32'd0);
    check("async_rst_volley", {30'd0, volley_cnt}, 32'd0);
    check("async_rst_fire", {26'd0, fire}, 32'd0);
    @(negedge clk22);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_warmup", {29'd0, sched_state}, 32'd1);

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
